// File: rtl/fsub_pkg.sv
// Shared definitions for the digit-serial subtractor.
//   state_t   : controller states (IDLE, RUN, DONE), 2-bit encoding.
//   cnt_width : width of the digit counter for a given WIDTH/DIGIT pair,
//               never less than one bit so a single-digit build still has
//               a legal counter.
package fsub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int cnt_width(input int width, input int digit);
    int ndig;
    ndig = width / digit;
    return (ndig <= 1) ? 1 : $clog2(ndig);
  endfunction

endpackage

// File: rtl/fsub_digit.sv
// Combinational DIGIT-bit subtract-with-borrow: {bo, d} = a_d - b_d - bi.
// Ports:
//   a_d [DIGIT] minuend digit      b_d [DIGIT] subtrahend digit
//   bi          borrow in          d   [DIGIT] difference digit
//   bo          borrow out (1 when a_d < b_d + bi)
module fsub_digit #(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] a_d,
  input  logic [DIGIT-1:0] b_d,
  input  logic             bi,
  output logic [DIGIT-1:0] d,
  output logic             bo
);

  // Extending by one bit turns the sign of the difference into the borrow:
  // the widest underflow is -2^DIGIT, which still sets the top bit.
  logic [DIGIT:0] full;

  always_comb begin
    full = {1'b0, a_d} - {1'b0, b_d} - {{DIGIT{1'b0}}, bi};
    d    = full[DIGIT-1:0];
    bo   = full[DIGIT];
  end

endmodule

// File: rtl/fsub_serial.sv
// Digit-serial unsigned subtractor: diff = (a - b - bin) mod 2^WIDTH,
// DIGIT bits per clock, LSB digit first, borrow held in a flop between digits.
// Ports:
//   clk, rst_n            clock (rising edge), async active-low reset
//   in_valid / in_ready   operand handshake; a, b, bin sampled at accept
//   a, b [WIDTH], bin     minuend, subtrahend, borrow-in
//   out_valid / out_ready result handshake
//   diff [WIDTH]          difference, held stable while out_valid
//   bout                  final borrow (a < b + bin)
//   zero                  diff == 0
module fsub_serial
  import fsub_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             zero
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = cnt_width(WIDTH, DIGIT);

  state_t           state_reg;
  logic [WIDTH-1:0] a_sh_reg;
  logic [WIDTH-1:0] b_sh_reg;
  logic [WIDTH-1:0] res_sh_reg;
  logic             borrow_reg;
  logic [CW-1:0]    cnt_reg;

  logic [DIGIT-1:0] d;
  logic             t;
  logic [WIDTH-1:0] res_next;

  fsub_digit #(.DIGIT(DIGIT)) u_digit (
    .a_d (a_sh_reg[DIGIT-1:0]),
    .b_d (b_sh_reg[DIGIT-1:0]),
    .bi  (borrow_reg),
    .d   (d),
    .bo  (t)
  );

  // New digit enters at the top; after NDIG shifts the first digit has
  // reached bit 0. A single-digit build has nothing to shift down.
  generate
    if (WIDTH == DIGIT) begin : g_one_digit
      assign res_next = d;
    end else begin : g_multi_digit
      assign res_next = {d, res_sh_reg[WIDTH-1:DIGIT]};
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      a_sh_reg   <= '0;
      b_sh_reg   <= '0;
      res_sh_reg <= '0;
      borrow_reg <= 1'b0;
      cnt_reg    <= '0;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      diff       <= '0;
      bout       <= 1'b0;
      zero       <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid && in_ready) begin
            a_sh_reg   <= a;
            b_sh_reg   <= b;
            borrow_reg <= bin;
            cnt_reg    <= '0;
            in_ready   <= 1'b0;
            state_reg  <= RUN;
          end
        end
        RUN: begin
          a_sh_reg   <= a_sh_reg >> DIGIT;
          b_sh_reg   <= b_sh_reg >> DIGIT;
          res_sh_reg <= res_next;
          borrow_reg <= t;
          cnt_reg    <= cnt_reg + 1'b1;
          if (cnt_reg == CW'(NDIG - 1)) begin
            // Flags are taken from the assembled word, not the shift reg,
            // so they stay consistent with diff for the whole DONE phase.
            diff      <= res_next;
            bout      <= t;
            zero      <= (res_next == '0);
            out_valid <= 1'b1;
            state_reg <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state_reg <= IDLE;
          end
        end
        default: begin
          state_reg <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fsub_serial.sv
module tb_fsub_serial;

  typedef struct packed {
    logic [7:0] d;
    logic       bo;
    logic       z;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // DUT 1: WIDTH=8, DIGIT=1
  logic       iv1 = 1'b0, ir1, bin1 = 1'b0, ov1, or1 = 1'b0, bo1, z1;
  logic [7:0] a1 = '0, b1 = '0, d1;
  // DUT 2: WIDTH=8, DIGIT=4
  logic       iv2 = 1'b0, ir2, bin2 = 1'b0, ov2, or2 = 1'b0, bo2, z2;
  logic [7:0] a2 = '0, b2 = '0, d2;

  fsub_serial #(.WIDTH(8), .DIGIT(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1), .a(a1), .b(b1),
    .bin(bin1), .out_valid(ov1), .out_ready(or1), .diff(d1), .bout(bo1), .zero(z1)
  );
  fsub_serial #(.WIDTH(8), .DIGIT(4)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv2), .in_ready(ir2), .a(a2), .b(b2),
    .bin(bin2), .out_valid(ov2), .out_ready(or2), .diff(d2), .bout(bo2), .zero(z2)
  );

  int checks = 0;
  int errors = 0;
  int rx1 = 0;
  int rx2 = 0;
  exp_t q1[$];
  exp_t q2[$];
  bit sends_done = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end else begin
      $display("ok   %s value=%0h", name, act);
    end
  endtask

  function automatic exp_t model(input logic [7:0] av, input logic [7:0] bv, input logic bi);
    logic [8:0] r;
    exp_t e;
    r    = {1'b0, av} - {1'b0, bv} - {8'd0, bi};
    e.d  = r[7:0];
    e.bo = r[8];
    e.z  = (r[7:0] == 8'd0);
    return e;
  endfunction

  // Monitors: pop the oldest expectation on every output handshake.
  always @(negedge clk) begin
    if (rst_n && ov1 && or1) begin
      if (q1.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL dut1_unexpected_result actual=%0h required=none", d1);
      end else begin
        exp_t e;
        e = q1.pop_front();
        rx1++;
        chk("dut1_diff", {24'd0, d1}, {24'd0, e.d});
        chk("dut1_bout", {31'd0, bo1}, {31'd0, e.bo});
        chk("dut1_zero", {31'd0, z1}, {31'd0, e.z});
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && ov2 && or2) begin
      if (q2.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL dut2_unexpected_result actual=%0h required=none", d2);
      end else begin
        exp_t e;
        e = q2.pop_front();
        rx2++;
        chk("dut2_diff", {24'd0, d2}, {24'd0, e.d});
        chk("dut2_bout", {31'd0, bo2}, {31'd0, e.bo});
        chk("dut2_zero", {31'd0, z2}, {31'd0, e.z});
      end
    end
  end

  // Present operands until accepted; returns 1 ns after the accept edge.
  task automatic send1(input logic [7:0] av, input logic [7:0] bv, input logic bi, input bit push);
    bit ok;
    ok = 1'b0;
    a1 = av; b1 = bv; bin1 = bi; iv1 = 1'b1;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (ir1) begin ok = 1'b1; break; end
    end
    if (!ok) chk("dut1_accept_timeout", 32'd0, 32'd1);
    if (push) q1.push_back(model(av, bv, bi));
    @(posedge clk); #1;
    iv1 = 1'b0;
    // Scramble operands after accept: they must not be re-sampled.
    a1 = 8'($urandom); b1 = 8'($urandom); bin1 = 1'($urandom);
  endtask

  task automatic drain1(input string name);
    bit ok;
    ok = 1'b0;
    or1 = 1'b1;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (ov1) begin ok = 1'b1; break; end
    end
    if (!ok) chk({name, "_out_timeout"}, 32'd0, 32'd1);
    @(posedge clk); #1;
    chk({name, "_ov_after_hs"}, {31'd0, ov1}, 32'd0);
    chk({name, "_ir_after_hs"}, {31'd0, ir1}, 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    #12;
    chk("rst_ir1", {31'd0, ir1}, 32'd1);
    chk("rst_ov1", {31'd0, ov1}, 32'd0);
    chk("rst_diff1", {24'd0, d1}, 32'd0);
    chk("rst_flags1", {30'd0, bo1, z1}, 32'd0);
    chk("rst_ir2", {31'd0, ir2}, 32'd1);
    chk("rst_ov2", {31'd0, ov2}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // 0x35 - 0x12: out_valid exactly 8 edges after accept
    send1(8'h35, 8'h12, 1'b0, 1'b1);
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk); #1;
      chk($sformatf("lat1_edge%0d", i), {31'd0, ov1}, (i == 8) ? 32'd1 : 32'd0);
    end
    chk("done_ir1_low", {31'd0, ir1}, 32'd0);
    drain1("v35");

    or1 = 1'b0;
    send1(8'h00, 8'h01, 1'b0, 1'b1);
    drain1("v00");
    or1 = 1'b0;
    send1(8'h80, 8'h7F, 1'b1, 1'b1);
    drain1("v80");

    // DUT 2, DIGIT=4: 0xA5 - 0x5A, out_valid 2 edges after accept
    a2 = 8'hA5; b2 = 8'h5A; bin2 = 1'b0; iv2 = 1'b1;
    @(negedge clk);
    chk("dut2_ready", {31'd0, ir2}, 32'd1);
    q2.push_back(model(8'hA5, 8'h5A, 1'b0));
    @(posedge clk); #1;
    iv2 = 1'b0; a2 = 8'hFF; b2 = 8'h00;
    @(posedge clk); #1;
    chk("lat2_edge1", {31'd0, ov2}, 32'd0);
    @(posedge clk); #1;
    chk("lat2_edge2", {31'd0, ov2}, 32'd1);
    or2 = 1'b1;
    @(posedge clk); #1;
    chk("dut2_ov_after_hs", {31'd0, ov2}, 32'd0);
    chk("dut2_ir_after_hs", {31'd0, ir2}, 32'd1);
    chk("dut2_rx", rx2, 32'd1);

    // Backpressure: 0x9C - 0x3E - 1 = 0x5D held for 5 cycles
    or1 = 1'b0;
    send1(8'h9C, 8'h3E, 1'b1, 1'b1);
    repeat (8) @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++) begin
      iv1 = 1'b1; a1 = 8'(i * 17); b1 = 8'(i * 3); bin1 = 1'(i);
      @(negedge clk);
      chk("bp_ov", {31'd0, ov1}, 32'd1);
      chk("bp_ir", {31'd0, ir1}, 32'd0);
      chk("bp_diff", {24'd0, d1}, 32'h5D);
      chk("bp_flags", {30'd0, bo1, z1}, 32'd0);
      @(posedge clk); #1;
    end
    iv1 = 1'b0;
    drain1("bp");

    // Reset in the middle of RUN
    or1 = 1'b0;
    send1(8'h55, 8'h11, 1'b0, 1'b0);
    @(posedge clk); @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("mrst_ov", {31'd0, ov1}, 32'd0);
    chk("mrst_diff", {24'd0, d1}, 32'd0);
    chk("mrst_flags", {30'd0, bo1, z1}, 32'd0);
    chk("mrst_ir", {31'd0, ir1}, 32'd1);
    q1.delete();
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_ir", {31'd0, ir1}, 32'd1);
    chk("post_rst_ov", {31'd0, ov1}, 32'd0);
    send1(8'h10, 8'h01, 1'b0, 1'b1);
    drain1("post_rst");

    // 20 random operations with random gaps and out_ready
    begin
      int base;
      base = rx1;
      fork
        begin
          for (int n = 0; n < 20; n++) begin
            int g;
            g = $urandom_range(0, 3);
            repeat (g) begin @(posedge clk); #1; end
            send1(8'($urandom), 8'($urandom), 1'($urandom), 1'b1);
          end
          sends_done = 1'b1;
        end
        begin
          while (!sends_done) begin
            @(posedge clk); #1;
            or1 = 1'($urandom_range(0, 1));
          end
          or1 = 1'b1;
        end
      join
      for (int i = 0; i < 200 && q1.size() > 0; i++) @(negedge clk);
      chk("rand_pending", q1.size(), 32'd0);
      chk("rand_received", rx1 - base, 32'd20);
    end

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
